// File: rtl/seg_display_arbiter_pkg.sv
// seg_display_arbiter_pkg: shared display constants, arbiter state encoding and round-robin pick
package seg_display_arbiter_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_A     = 7'b0001000;

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    // First requester after last in the cyclic order 0,1,2; returns last if none.
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] p;
        logic [1:0] k;
        p = last;
        for (int i = 3; i >= 1; i--) begin
            k = 2'((int'(last) + i) % 3);
            if (r[k]) p = k;
        end
        return p;
    endfunction

endpackage

// File: rtl/seg_display_arbiter_scan_timer.sv
// seg_scan_timer: digit-slot divider and 2-bit digit index for the display scan
module seg_scan_timer
    import seg_display_arbiter_pkg::*;
#(
    parameter int SCAN_DIV = 262144
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    output logic       tick,
    output logic [1:0] digit,
    output logic       frame_end
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] div;

    assign tick      = div == DW'(SCAN_DIV - 1);
    assign frame_end = tick && digit == 2'd3;

    always_ff @(posedge CLOCK or negedge RESET_N)
        if (!RESET_N) begin
            div   <= '0;
            digit <= '0;
        end else begin
            div   <= tick ? '0 : div + 1'b1;
            digit <= tick ? digit + 2'd1 : digit;
        end

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin owner of the 4-digit display with frame snapshots and scan drive
module seg_display_arbiter
    import seg_display_arbiter_pkg::*;
#(
    parameter int SCAN_DIV    = 262144,
    parameter int HOLD_FRAMES = 4
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic [2:0]  req,
    input  logic [27:0] digits0,
    input  logic [27:0] digits1,
    input  logic [27:0] digits2,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic [2:0]  grant,
    output logic        frame_done
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    state_t        state, nxt_state, st_eff;
    logic [1:0]    owner, last_grant, nxt_owner, digit, ndig;
    logic [HW-1:0] hold_cnt, hold_inc, nxt_hold;
    logic [27:0]   snapshot, nxt_snap;
    logic [2:0]    others;
    logic          tick, frame_end, arb, rot;

    seg_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .tick      (tick),
        .digit     (digit),
        .frame_end (frame_end)
    );

    // A lost owner and an idle display both arbitrate freshly; rot is the contested-hold rotation.
    always_comb begin
        ndig      = digit + 2'd1;
        hold_inc  = hold_cnt == HW'(HOLD_FRAMES) ? hold_cnt : hold_cnt + 1'b1;
        others    = req & ~(3'b001 << owner);
        arb       = state == IDLE || !req[owner];
        rot       = !arb && hold_inc == HW'(HOLD_FRAMES) && |others;
        nxt_state = arb && !(|req) ? IDLE : OWN;
        nxt_owner = arb ? rr_pick(req, last_grant) : rot ? rr_pick(others, last_grant) : owner;
        nxt_hold  = arb || rot ? '0 : hold_inc;
        nxt_snap  = nxt_state == IDLE ? {4{SEG_BLANK}} :
                    nxt_owner == 2'd0 ? digits0 : nxt_owner == 2'd1 ? digits1 : digits2;
        st_eff    = frame_end ? nxt_state : state;
    end

    always_ff @(posedge CLOCK or negedge RESET_N)
        if (!RESET_N) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= 2'd2;
            hold_cnt   <= '0;
            snapshot   <= {4{SEG_BLANK}};
            grant      <= '0;
            an         <= AN_OFF;
            seg        <= SEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                state      <= nxt_state;
                owner      <= nxt_owner;
                hold_cnt   <= nxt_hold;
                snapshot   <= nxt_snap;
                last_grant <= nxt_state == OWN ? nxt_owner : last_grant;
                grant      <= nxt_state == OWN ? 3'b001 << nxt_owner : 3'b000;
            end
            // Digit 0 of a new frame comes straight from the incoming snapshot.
            if (tick) begin
                an  <= st_eff == IDLE ? AN_OFF : ~(4'b0001 << ndig);
                seg <= st_eff == IDLE ? SEG_BLANK : frame_end ? nxt_snap[6:0] : snapshot[7*ndig +: 7];
            end
        end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb_seg_display_arbiter: directed test-plan scenarios plus random traffic against a frame-level model
module tb_seg_display_arbiter;
    import seg_display_arbiter_pkg::*;

    localparam int SD = 4;
    localparam int HF = 2;
    localparam int FR = 4 * SD;

    logic        CLOCK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [2:0]  req = '0;
    logic [27:0] digits0 = '1, digits1 = '1, digits2 = '1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [2:0]  grant;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    always #5 CLOCK = ~CLOCK;

    seg_display_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
        .CLOCK      (CLOCK),
        .RESET_N    (RESET_N),
        .req        (req),
        .digits0    (digits0),
        .digits1    (digits1),
        .digits2    (digits2),
        .an         (an),
        .seg        (seg),
        .grant      (grant),
        .frame_done (frame_done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: cycles since reset, frame owner (-1 idle), last grant, frames already shown.
    int          m_n = 0, m_own = -1, m_last = 2, m_held = 0, nxt;
    logic [27:0] m_snap = '1;
    bit          en_cmp = 0;

    function automatic int rr(input logic [2:0] r, input int from);
        int k;
        for (int i = 1; i <= 3; i++) begin
            k = (from + i) % 3;
            if (r[k[1:0]]) return k;
        end
        return -1;
    endfunction

    function automatic int model_arb(input logic [2:0] r, input int own, input int last, input int held);
        logic [2:0] rest;
        if (own < 0) return rr(r, last);
        if (!r[own[1:0]]) return rr(r, last);
        rest = r & ~(3'b001 << own);
        if (held + 1 >= HF && rest != 3'b000) return rr(rest, own);
        return own;
    endfunction

    always @(posedge CLOCK or negedge RESET_N)
        if (!RESET_N) begin
            m_n    <= 0;
            m_own  <= -1;
            m_last <= 2;
            m_held <= 0;
            m_snap <= '1;
        end else begin
            m_n <= m_n + 1;
            if ((m_n + 1) % FR == 0) begin
                nxt = model_arb(req, m_own, m_last, m_held);
                m_own  <= nxt;
                m_held <= (nxt == m_own && nxt >= 0) ? m_held + 1 : 0;
                if (nxt >= 0) m_last <= nxt;
                m_snap <= nxt == 0 ? digits0 : nxt == 1 ? digits1 : digits2;
            end
        end

    int         slot;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [2:0] e_grant;
    logic       e_fd;

    always @(negedge CLOCK)
        if (en_cmp) begin
            slot    = (m_n / SD) % 4;
            e_an    = m_own < 0 ? 4'hF : ~(4'b0001 << slot);
            e_seg   = m_own < 0 ? 7'h7F : m_snap[7*slot +: 7];
            e_grant = m_own < 0 ? 3'b000 : 3'b001 << m_own;
            e_fd    = m_n > 0 && m_n % FR == 0;
            chk("cmp_an", an, e_an);
            chk("cmp_seg", seg, e_seg);
            chk("cmp_grant", grant, e_grant);
            chk("cmp_frame_done", frame_done, e_fd);
        end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] r_during, input logic [2:0] r_after);
        @(posedge CLOCK);
        #2;
        RESET_N = 1'b0;
        req = r_during;
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_grant", grant, 3'b000);
        @(posedge CLOCK);
        @(posedge CLOCK);
        #2;
        req = r_after;
        RESET_N = 1'b1;
    endtask

    logic [2:0] hold_seq [6] = '{3'b001, 3'b001, 3'b100, 3'b100, 3'b001, 3'b001};
    logic [3:0] an_seq   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] seg_seq  [4] = '{7'b0001000, 7'b1000000, 7'b1000111, 7'b1111111};

    initial begin
        do_reset(3'($urandom), 3'b000);
        en_cmp = 1;
        cyc(20);
        chk("idle_an", an, 4'hF);
        chk("idle_seg", seg, 7'h7F);
        chk("idle_grant", grant, 3'b000);

        digits1 = {SEG_BLANK, SEG_L, SEG_O, SEG_A};
        do_reset(3'b010, 3'b010);
        cyc(16);
        chk("single_grant", grant, 3'b010);
        chk("single_fd", frame_done, 1'b1);
        for (int d = 0; d < 4; d++) begin
            if (d > 0) cyc(4);
            chk("single_an", an, an_seq[d]);
            chk("single_seg", seg, seg_seq[d]);
        end

        cyc(8);
        digits1 = {4{SEG_A}};
        chk("dchg_old1", seg, 7'b1000000);
        cyc(4);
        chk("dchg_old2", seg, 7'b1000111);
        cyc(4);
        chk("dchg_old3", seg, 7'b1111111);
        cyc(8);
        chk("dchg_new1", seg, 7'b0001000);
        chk("dchg_an", an, 4'b1101);

        digits0 = {SEG_L, SEG_L, SEG_O, SEG_O};
        req = 3'b001;
        cyc(4);
        chk("dropA_keep", grant, 3'b010);
        chk("dropA_seg", seg, 7'b0001000);
        cyc(8);
        chk("dropA_grant", grant, 3'b001);
        chk("dropA_seg0", seg, 7'b1000000);
        chk("dropA_an", an, 4'b1110);

        do_reset(3'b000, 3'b010);
        cyc(20);
        chk("dropB_own", grant, 3'b010);
        req = 3'b000;
        cyc(4);
        chk("dropB_keep", grant, 3'b010);
        chk("dropB_an2", an, 4'b1011);
        cyc(8);
        chk("dropB_grant", grant, 3'b000);
        chk("dropB_an", an, 4'hF);
        chk("dropB_seg", seg, 7'h7F);

        do_reset(3'b101, 3'b101);
        cyc(16);
        for (int k = 0; k < 6; k++) begin
            chk("hold_grant", grant, hold_seq[k]);
            chk("hold_fd_hi", frame_done, 1'b1);
            cyc(1);
            chk("hold_fd_lo", frame_done, 1'b0);
            cyc(15);
        end

        do_reset(3'b111, 3'b111);
        cyc(48);
        chk("midrst_pre", grant, 3'b010);
        cyc(8);
        #1;
        RESET_N = 1'b0;
        #1;
        chk("midrst_an", an, 4'hF);
        chk("midrst_seg", seg, 7'h7F);
        chk("midrst_grant", grant, 3'b000);
        chk("midrst_fd", frame_done, 1'b0);
        @(posedge CLOCK);
        #2;
        RESET_N = 1'b1;
        cyc(16);
        chk("midrst_first", grant, 3'b001);

        do_reset(3'b000, 3'($urandom));
        for (int c = 0; c < 4000; c++) begin
            @(posedge CLOCK);
            #1;
            if ($urandom_range(7) == 0) req = 3'($urandom);
            if ($urandom_range(15) == 0) begin
                case ($urandom_range(2))
                    0: digits0 = 28'($urandom);
                    1: digits1 = 28'($urandom);
                    default: digits2 = 28'($urandom);
                endcase
            end
            if ($urandom_range(999) == 0) begin
                #1;
                RESET_N = 1'b0;
                #2;
                RESET_N = 1'b1;
            end
        end

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
